dmem_access_ctrl: RTL and testbench

- Memory-stage initiator for the Y86-64 SEQ datapath. Decodes icode into a single read or write transaction and drives a valid/ready request, response-valid data-memory port.
- Returns valM and a done/error status to the stage sequencer; holds busy while a transaction is outstanding.

---
 rtl/y86_pkg.sv | 11 +
 rtl/dmem_op_decode.sv | 21 ++
 rtl/dmem_access_ctrl.sv | 93 +++++++++
 tb/tb_dmem_access_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode constants, word type and memory-stage FSM states
package y86_pkg;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;
   typedef logic [63:0] word_t;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RESP, S_DONE} state_t;
endpackage

// File: rtl/dmem_op_decode.sv
// dmem_op_decode: maps an icode and its operands to one data-memory transaction
module dmem_op_decode
   import y86_pkg::*;
(
   input  logic [3:0]  icode,
   input  logic [63:0] valA,
   input  logic [63:0] valE,
   input  logic [63:0] valP,
   output logic        is_mem,
   output logic        is_write,
   output logic [63:0] addr,
   output logic [63:0] wdata
);
   logic is_read;
   assign is_write = icode inside {ICODE_RMMOVQ, ICODE_CALL, ICODE_PUSHQ};
   assign is_read  = icode inside {ICODE_MRMOVQ, ICODE_RET, ICODE_POPQ};
   assign is_mem   = is_write || is_read;
   // ret/popq read through the stack pointer carried in valA
   assign addr     = (icode == ICODE_RET || icode == ICODE_POPQ) ? valA : valE;
   assign wdata    = (icode == ICODE_CALL) ? valP : valA;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: Y86-64 memory-stage initiator driving a valid/ready data-memory port
module dmem_access_ctrl
   import y86_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic [63:0] valA,
   input  logic [63:0] valE,
   input  logic [63:0] valP,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [63:0] valM,
   output logic        req_valid,
   output logic        req_write,
   output logic [63:0] req_addr,
   output logic [63:0] req_wdata,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [63:0] resp_rdata,
   input  logic        resp_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic           is_mem, is_write, in_range, go_req, timed_out;
   word_t          addr, wdata;
   dmem_op_decode u_decode (
      .icode    (icode),
      .valA     (valA),
      .valE     (valE),
      .valP     (valP),
      .is_mem   (is_mem),
      .is_write (is_write),
      .addr     (addr),
      .wdata    (wdata)
   );
   assign in_range  = addr < 64'(MEM_WORDS);
   assign go_req    = is_mem && in_range;
   assign timed_out = cnt == CW'(TIMEOUT - 1);
   assign busy      = state != S_IDLE;
   assign done      = state == S_DONE;
   assign req_valid = state == S_REQ;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      state_nx = !start ? S_IDLE : go_req ? S_REQ : S_DONE;
         S_REQ:       state_nx = req_ready ? S_WAIT_RESP : S_REQ;
         S_WAIT_RESP: state_nx = (resp_valid || timed_out) ? S_DONE : S_WAIT_RESP;
         default:     state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error     <= 1'b0;
         valM      <= '0;
         req_write <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               error <= is_mem && !in_range;
               if (go_req) begin
                  req_write <= is_write;
                  req_addr  <= addr;
                  req_wdata <= wdata;
               end
            end
            S_REQ: cnt <= '0;
            S_WAIT_RESP: begin
               cnt <= cnt + CW'(1);
               // a response arriving on the timeout edge still wins
               if (resp_valid) begin
                  error <= resp_err;
                  if (!resp_err && !req_write) valM <= resp_rdata;
               end else if (timed_out) error <= 1'b1;
            end
            default: error <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: transaction-level model checked against the DUT every cycle
module tb_dmem_access_ctrl;
   localparam int MW = 1024;
   localparam int TO = 16;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [3:0]  icode = '0;
   logic [63:0] valA = '0, valE = '0, valP = '0;
   logic        busy, done, error, req_valid, req_write;
   logic [63:0] valM, req_addr, req_wdata;
   logic        req_ready = 1'b0, resp_valid = 1'b0, resp_err = 1'b0;
   logic [63:0] resp_rdata = '0;
   int checks = 0, errors = 0, cyc = 0;
   bit chk_en = 1'b0;
   int t_s = -10, t_d = -10, t_rd = 0;
   logic t_ok = 1'b0, t_err = 1'b0;
   logic m_write = 1'b0;
   logic [63:0] m_addr = '0, m_wdata = '0, mv_before = '0, mv_after = '0;
   int last_done = 0, req_cnt = 0, op_start = 0;
   logic last_err = 1'b0, last_write = 1'b0;
   logic [63:0] last_addr = '0, last_wdata = '0;
   logic e_busy, e_rv;

   dmem_access_ctrl #(.MEM_WORDS(MW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
      .valA(valA), .valE(valE), .valP(valP),
      .busy(busy), .done(done), .error(error), .valM(valM),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs follow from the transaction window [t_s, t_d] alone.
   always @(negedge clk) if (chk_en) begin
      e_busy = cyc >= t_s && cyc <= t_d;
      e_rv   = t_ok && cyc >= t_s && cyc <= t_s + t_rd;
      chk("busy", busy, e_busy);
      chk("done", done, cyc == t_d);
      chk("error", error, (cyc == t_d) ? t_err : 1'b0);
      chk("req_valid", req_valid, e_rv);
      chk("valM", valM, (cyc >= t_d) ? mv_after : mv_before);
      if (e_rv) begin
         chk("req_write", req_write, m_write);
         chk("req_addr", req_addr, m_addr);
         chk("req_wdata", req_wdata, m_wdata);
      end
      if (done) begin
         last_done = cyc;
         last_err  = error;
      end
      if (req_valid) begin
         req_cnt++;
         last_write = req_write;
         last_addr  = req_addr;
         last_wdata = req_wdata;
      end
   end

   task automatic spec_decode(input logic [3:0] ic, input logic [63:0] a, e, p,
                              output logic mem, wr, output logic [63:0] ad, wd);
      mem = 1'b1; wr = 1'b0; ad = e; wd = a;
      case (ic)
         4'h4: wr = 1'b1;
         4'h5: ;
         4'h8: begin wr = 1'b1; wd = p; end
         4'h9: ad = a;
         4'hA: wr = 1'b1;
         4'hB: ad = a;
         default: mem = 1'b0;
      endcase
   endtask

   // rd: cycles req_ready is withheld; w: wait cycles before response (>=TO means none in time)
   task automatic op(input logic [3:0] ic, input logic [63:0] a, e, p, input int rd, w,
                     input logic [63:0] rdata, input logic rerr, input bit bstart, input int rst_at);
      logic mem, wr;
      logic [63:0] ad, wd;
      int s;
      bit stop;
      spec_decode(ic, a, e, p, mem, wr, ad, wd);
      s         = cyc + 1;
      op_start  = cyc;
      req_cnt   = 0;
      t_ok      = mem && ad < 64'(MW);
      t_rd      = rd;
      t_d       = !t_ok ? s : s + rd + 2 + ((w < TO) ? w : TO - 1);
      t_err     = mem && (!t_ok || w >= TO || rerr);
      m_write   = wr;
      m_addr    = ad;
      m_wdata   = wd;
      mv_before = mv_after;
      mv_after  = (t_ok && !wr && w < TO && !rerr) ? rdata : mv_before;
      t_s       = s;
      icode = ic; valA = a; valE = e; valP = p;
      resp_rdata = rdata; resp_err = rerr;
      start = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      while (!stop && cyc <= t_d) begin
         req_ready  = t_ok && cyc == s + rd;
         resp_valid = t_ok && cyc == s + rd + 1 + w;
         start      = bstart && cyc == s + 1;
         icode      = (bstart && cyc == s + 1) ? 4'h6 : 4'(cyc);
         valA = {$urandom, $urandom}; valE = {$urandom, $urandom}; valP = {$urandom, $urandom};
         if (rst_at >= 0 && cyc == s + rst_at) begin
            #2;
            t_s = -10; t_d = -10; t_ok = 1'b0; mv_before = '0; mv_after = '0;
            rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 1'b0);
            chk("rst_req_valid", req_valid, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_valM", valM, 64'h0);
            chk("rst_req_addr", req_addr, 64'h0);
            stop = 1'b1;
         end
         step();
      end
      req_ready = 1'b0; resp_valid = 1'b0; start = 1'b0;
      if (stop) begin
         step();
         rst_n = 1'b1;
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_error", error, 1'b0);
      chk("reset_req_valid", req_valid, 1'b0);
      chk("reset_req_write", req_write, 1'b0);
      chk("reset_req_addr", req_addr, 64'h0);
      chk("reset_req_wdata", req_wdata, 64'h0);
      chk("reset_valM", valM, 64'h0);
      step();
      rst_n = 1'b1;
      step();
      chk_en = 1'b1;
      op(4'h4, 64'hDEAD, 64'd5, 64'h0, 0, 0, 64'h1111, 1'b0, 1'b0, -1);
      chk("rmmovq_write", last_write, 1'b1);
      chk("rmmovq_addr", last_addr, 64'd5);
      chk("rmmovq_wdata", last_wdata, 64'hDEAD);
      chk("rmmovq_latency", 64'(last_done - op_start + 1), 64'd4);
      chk("rmmovq_valM_kept", valM, 64'h0);
      op(4'h5, 64'h0, 64'd5, 64'h0, 0, 3, 64'hDEAD, 1'b0, 1'b0, -1);
      chk("mrmovq_valM", valM, 64'hDEAD);
      op(4'h8, 64'h99, 64'd1022, 64'h40, 0, 0, 64'h0, 1'b0, 1'b0, -1);
      chk("call_addr", last_addr, 64'd1022);
      chk("call_wdata", last_wdata, 64'h40);
      op(4'h9, 64'd1022, 64'h0, 64'h0, 0, 1, 64'h40, 1'b0, 1'b0, -1);
      chk("ret_valM", valM, 64'h40);
      op(4'hB, 64'd7, 64'h0, 64'h0, 0, 0, 64'h77, 1'b0, 1'b0, -1);
      chk("popq_addr", last_addr, 64'd7);
      chk("popq_valM", valM, 64'h77);
      op(4'h4, 64'h5, 64'd1024, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0, -1);
      chk("oor_no_req", 64'(req_cnt), 64'd0);
      chk("oor_latency", 64'(last_done - op_start + 1), 64'd2);
      chk("oor_error", last_err, 1'b1);
      op(4'h5, 64'h0, 64'd9, 64'h0, 0, 2, 64'hBAD, 1'b1, 1'b0, -1);
      chk("resp_err_error", last_err, 1'b1);
      chk("resp_err_valM", valM, 64'h77);
      op(4'h5, 64'h0, 64'd9, 64'h0, 0, 100, 64'hCAFE, 1'b0, 1'b0, -1);
      chk("timeout_error", last_err, 1'b1);
      chk("timeout_latency", 64'(last_done - op_start + 1), 64'd19);
      op(4'h5, 64'h0, 64'd10, 64'h0, 0, TO - 1, 64'hBEEF, 1'b0, 1'b0, -1);
      chk("edge_resp_wins", valM, 64'hBEEF);
      op(4'h6, 64'h1, 64'h2, 64'h3, 0, 0, 64'h0, 1'b0, 1'b0, -1);
      chk("nonmem_latency", 64'(last_done - op_start + 1), 64'd2);
      chk("nonmem_no_req", 64'(req_cnt), 64'd0);
      op(4'hA, 64'h1234, 64'd20, 64'h0, 2, 0, 64'h0, 1'b0, 1'b1, -1);
      op(4'hA, 64'h5678, 64'd21, 64'h0, 5, 0, 64'h0, 1'b0, 1'b0, -1);
      chk("stall_req_cycles", 64'(req_cnt), 64'd6);
      chk("stall_wdata", last_wdata, 64'h5678);
      resp_valid = 1'b1; resp_rdata = 64'hFFFF; resp_err = 1'b0;
      step();
      resp_valid = 1'b0;
      step();
      op(4'h5, 64'h0, 64'd3, 64'h0, 0, 100, 64'h9999, 1'b0, 1'b0, 3);
      op(4'h5, 64'h0, 64'd4, 64'h0, 0, 0, 64'h4242, 1'b0, 1'b0, -1);
      chk("post_reset_valM", valM, 64'h4242);
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
